// File: rtl/m107_pkg.sv
// Shared types and constants for the m107 ROM responder.
package m107_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIT  = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } rom_resp_state_t;

    localparam int ROM_LINE_BYTES = 8;

    // Pick one 16-bit word out of a 64-bit line; word 0 lives in bits [15:0].
    function automatic logic [15:0] line_word(input logic [63:0] line, input logic [1:0] ws);
        logic [15:0] word;
        case (ws)
            2'd0:    word = line[15:0];
            2'd1:    word = line[31:16];
            2'd2:    word = line[47:32];
            2'd3:    word = line[63:48];
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/m107_rom_responder.sv
// Services CPU ROM word reads from SDRAM through a single 64-bit line buffer.
module m107_rom_responder
    import m107_pkg::*;
#(
    parameter logic [24:0] ROM_BASE = 25'h0000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd_req,
    input  logic        cpu_rom_memrq,
    input  logic [19:0] rom_addr,
    input  logic        invalidate,
    output logic [15:0] cpu_dout,
    output logic        cpu_ready,
    output logic        busy,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_ack,
    input  logic [63:0] sdr_data
);

    rom_resp_state_t state_r;
    logic            line_valid_r;
    logic [16:0]     line_tag_r;
    logic [63:0]     line_data_r;
    logic [19:1]     addr_r;
    logic            fill_inv_r;

    logic            accept_s;
    logic            hit_s;
    logic            ack_match_s;
    logic [24:0]     fill_addr_s;
    logic            unused_addr_bit_s;

    // Request qualification, hit detection and fill address (wraps modulo 2^25).
    always_comb begin
        accept_s          = cpu_rd_req & cpu_rom_memrq & (state_r == ST_IDLE);
        hit_s             = line_valid_r & (line_tag_r == rom_addr[19:3]) & ~invalidate;
        ack_match_s       = (sdr_ack == sdr_req);
        fill_addr_s       = ROM_BASE + (25'(rom_addr[19:3]) * 25'(ROM_LINE_BYTES));
        unused_addr_bit_s = rom_addr[0];
    end

    // Main responder FSM, SDRAM toggle handshake and registered CPU outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            line_tag_r  <= 17'd0;
            line_data_r <= 64'd0;
            addr_r      <= 19'd0;
            fill_inv_r  <= 1'b0;
            cpu_dout    <= 16'h0000;
            cpu_ready   <= 1'b0;
            busy        <= 1'b0;
            sdr_addr    <= 25'd0;
            sdr_req     <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r     <= rom_addr[19:1];
                        busy       <= 1'b1;
                        fill_inv_r <= 1'b0;
                        if (hit_s) begin
                            state_r <= ST_HIT;
                        end else begin
                            state_r  <= ST_FILL;
                            sdr_addr <= fill_addr_s;
                            sdr_req  <= ~sdr_req;
                        end
                    end
                end
                ST_HIT, ST_RESP: begin
                    cpu_dout  <= line_word(line_data_r, addr_r[2:1]);
                    cpu_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                ST_FILL: begin
                    // Remember any invalidate seen while the fill is in flight.
                    if (invalidate) begin
                        fill_inv_r <= 1'b1;
                    end
                    if (ack_match_s) begin
                        line_data_r <= sdr_data;
                        line_tag_r  <= addr_r[19:3];
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Line valid flag: invalidate wins in every state, including the fill completion cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_valid_r <= 1'b0;
        end else if ((state_r == ST_FILL) && ack_match_s) begin
            line_valid_r <= ~(fill_inv_r | invalidate);
        end else if (invalidate) begin
            line_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_m107_rom_responder.sv
// Self-checking bench: directed vector table, reset/wrap sequences and a randomized run against a line-buffer model.
module tb_m107_rom_responder;

    logic        clk = 1'b0;
    logic        reset, cpu_rd_req, cpu_rom_memrq, invalidate, sdr_ack;
    logic [19:0] rom_addr;
    logic [63:0] sdr_data;
    logic [15:0] cpu_dout;
    logic        cpu_ready, busy, sdr_req;
    logic [24:0] sdr_addr;

    logic [15:0] wrap_dout_unused;
    logic        wrap_ready_unused, wrap_busy_unused;
    logic        wrap_req, wrap_ack;
    logic [24:0] wrap_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    m107_rom_responder u_dut (
        .clk(clk), .reset(reset), .cpu_rd_req(cpu_rd_req), .cpu_rom_memrq(cpu_rom_memrq),
        .rom_addr(rom_addr), .invalidate(invalidate), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
        .busy(busy), .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_data(sdr_data)
    );

    // Second instance only exercises the 25-bit address wrap; its SDRAM acks instantly.
    assign wrap_ack = wrap_req;
    m107_rom_responder #(.ROM_BASE(25'h1FFFFF8)) u_wrap (
        .clk(clk), .reset(reset), .cpu_rd_req(cpu_rd_req), .cpu_rom_memrq(cpu_rom_memrq),
        .rom_addr(rom_addr), .invalidate(invalidate), .cpu_dout(wrap_dout_unused),
        .cpu_ready(wrap_ready_unused), .busy(wrap_busy_unused), .sdr_addr(wrap_addr),
        .sdr_req(wrap_req), .sdr_ack(wrap_ack), .sdr_data(sdr_data)
    );

    typedef struct {
        logic [19:0] addr;
        logic        memrq;
        int          ack_dly;
        int          inval_cyc;
        logic        busy_req;
        logic [63:0] data;
        int          exp_toggle;
        logic [24:0] exp_sdr_addr;
        logic [15:0] exp_dout;
        int          exp_lat;
    } vec_t;

    localparam logic [63:0] D1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] D2 = 64'h8888_7777_6666_5555;
    localparam logic [63:0] D3 = 64'hDDDD_CCCC_BBBB_AAAA;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_rd_req = 1'b0; cpu_rom_memrq = 1'b0; invalidate = 1'b0;
        sdr_ack = 1'b0; rom_addr = 20'h0; sdr_data = 64'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout", cpu_dout, 16'h0);
        check("rst_ready", cpu_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sdr_req", sdr_req, 1'b0);
        check("rst_sdr_addr", sdr_addr, 25'h0);
        reset = 1'b0;
    endtask

    // Called at a negedge: that cycle is the request cycle (cycle 0).
    task automatic do_read(input logic [19:0] addr, input logic memrq, input int ack_dly,
                           input int inval_cyc, input logic busy_req, input logic [63:0] data,
                           input int max_cyc, output int n_ready, output int n_toggle,
                           output int lat, output logic [15:0] dout, output logic [24:0] saddr,
                           output logic busy1, output logic busy_end);
        logic prev_req;
        int   ack_at;
        n_ready = 0; n_toggle = 0; lat = 0; dout = 16'h0; saddr = 25'h0;
        busy1 = 1'b0; busy_end = 1'b1; ack_at = -1;
        prev_req = sdr_req;
        cpu_rd_req = 1'b1; cpu_rom_memrq = memrq; rom_addr = addr;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            cpu_rd_req = 1'b0; cpu_rom_memrq = 1'b0; invalidate = 1'b0;
            sdr_data = {$urandom, $urandom};
            if (cyc == inval_cyc) invalidate = 1'b1;
            if (busy_req && cyc == 2) begin
                cpu_rd_req = 1'b1; cpu_rom_memrq = 1'b1; rom_addr = addr ^ 20'h00040;
            end
            if (sdr_req !== prev_req) begin
                n_toggle++;
                prev_req = sdr_req;
                if (n_toggle == 1) begin
                    saddr  = sdr_addr;
                    ack_at = cyc + ack_dly;
                end
            end
            if (cyc == ack_at) begin
                sdr_ack  = sdr_req;
                sdr_data = data;
            end
            if (cyc == 1) busy1 = busy;
            if (cpu_ready) begin
                n_ready++;
                if (n_ready == 1) begin
                    lat  = cyc;
                    dout = cpu_dout;
                end
            end
            if (n_ready > 0 && cyc == lat + 1) begin
                busy_end = busy;
                break;
            end
        end
        invalidate = 1'b0; cpu_rd_req = 1'b0; cpu_rom_memrq = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          n_ready, n_toggle, lat;
        logic [15:0] dout;
        logic [24:0] saddr;
        logic        busy1, busy_end;
        do_read(v.addr, v.memrq, v.ack_dly, v.inval_cyc, v.busy_req, v.data,
                (v.exp_lat > 0) ? 30 : 6, n_ready, n_toggle, lat, dout, saddr, busy1, busy_end);
        check({tag, "_ready_count"}, n_ready, (v.exp_lat > 0) ? 1 : 0);
        check({tag, "_toggles"}, n_toggle, v.exp_toggle);
        check({tag, "_busy1"}, busy1, (v.exp_lat > 0) ? 1'b1 : 1'b0);
        if (v.exp_toggle > 0) check({tag, "_sdr_addr"}, saddr, v.exp_sdr_addr);
        if (v.exp_lat > 0) begin
            check({tag, "_dout"}, dout, v.exp_dout);
            check({tag, "_latency"}, lat, v.exp_lat);
            check({tag, "_busy_end"}, busy_end, 1'b0);
        end
    endtask

    vec_t        vecs[13];
    vec_t        rv;
    logic        m_valid, hit, ready_seen;
    logic [16:0] m_tag;
    logic [63:0] m_data, line;

    initial begin
        vecs[0]  = '{20'h00002, 1'b1, 3, 0, 1'b0, D1, 1, 25'h000000, 16'h2222, 6};
        vecs[1]  = '{20'h00000, 1'b1, 0, 0, 1'b0, D3, 0, 25'h000000, 16'h1111, 2};
        vecs[2]  = '{20'h00006, 1'b1, 0, 0, 1'b0, D3, 0, 25'h000000, 16'h4444, 2};
        vecs[3]  = '{20'h00008, 1'b1, 0, 0, 1'b0, D2, 1, 25'h000008, 16'h5555, 3};
        vecs[4]  = '{20'h0000C, 1'b1, 0, 0, 1'b0, D3, 0, 25'h000000, 16'h7777, 2};
        vecs[5]  = '{20'h00002, 1'b1, 2, 2, 1'b0, D1, 1, 25'h000000, 16'h2222, 5};
        vecs[6]  = '{20'h00004, 1'b1, 1, 0, 1'b0, D3, 1, 25'h000000, 16'hCCCC, 4};
        vecs[7]  = '{20'h00005, 1'b1, 0, 0, 1'b0, D1, 0, 25'h000000, 16'hCCCC, 2};
        vecs[8]  = '{20'h00010, 1'b0, 0, 0, 1'b0, D1, 0, 25'h000000, 16'h0000, 0};
        vecs[9]  = '{20'h00018, 1'b1, 4, 0, 1'b1, D2, 1, 25'h000018, 16'h5555, 7};
        vecs[10] = '{20'h0001A, 1'b1, 0, 0, 1'b0, D1, 0, 25'h000000, 16'h6666, 2};
        vecs[11] = '{20'h0001E, 1'b1, 0, 1, 1'b0, D1, 0, 25'h000000, 16'h8888, 2};
        vecs[12] = '{20'h00018, 1'b1, 0, 0, 1'b0, D3, 1, 25'h000018, 16'hAAAA, 3};

        // Address wrap on the second instance.
        do_reset();
        run_vec("wrap_main", '{20'h00008, 1'b1, 1, 0, 1'b0, D2, 1, 25'h000008, 16'h5555, 4});
        check("wrap_sdr_addr", wrap_addr, 25'h0000000);

        do_reset();
        for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a fill.
        cpu_rd_req = 1'b1; cpu_rom_memrq = 1'b1; rom_addr = 20'h00100;
        @(negedge clk);
        cpu_rd_req = 1'b0; cpu_rom_memrq = 1'b0;
        check("midfill_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1; sdr_ack = 1'b0;
        @(negedge clk);
        check("midfill_rst_req", sdr_req, 1'b0);
        check("midfill_rst_addr", sdr_addr, 25'h0);
        check("midfill_rst_dout", cpu_dout, 16'h0);
        check("midfill_rst_ready", cpu_ready, 1'b0);
        check("midfill_rst_busy", busy, 1'b0);
        reset = 1'b0;
        ready_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_ready) ready_seen = 1'b1;
        end
        check("midfill_no_ready", ready_seen, 1'b0);
        run_vec("post_reset", '{20'h00100, 1'b1, 2, 0, 1'b0, D2, 1, 25'h000100, 16'h5555, 5});
        check("post_reset_req_level", sdr_req, 1'b1);

        // Randomized run against a one-line buffer model.
        do_reset();
        m_valid = 1'b0; m_tag = 17'h0; m_data = 64'h0;
        for (int i = 0; i < 80; i++) begin
            rv.addr      = 20'($urandom_range(0, 31));
            rv.memrq     = ($urandom_range(0, 9) != 0);
            rv.ack_dly   = $urandom_range(0, 5);
            rv.data      = {$urandom, $urandom};
            hit          = m_valid && (m_tag == rv.addr[19:3]);
            rv.exp_lat   = !rv.memrq ? 0 : (hit ? 2 : 3 + rv.ack_dly);
            rv.inval_cyc = (rv.memrq && $urandom_range(0, 4) == 0) ? $urandom_range(1, rv.exp_lat) : 0;
            rv.busy_req  = rv.memrq && !hit && rv.ack_dly >= 2 && ($urandom_range(0, 1) == 1);
            rv.exp_toggle   = (rv.memrq && !hit) ? 1 : 0;
            rv.exp_sdr_addr = 25'(rv.addr[19:3]) * 25'd8;
            line         = hit ? m_data : rv.data;
            rv.exp_dout  = 16'((line >> (16 * int'(rv.addr[2:1]))) & 64'hFFFF);
            run_vec($sformatf("rand%0d", i), rv);
            if (rv.memrq) begin
                if (!hit) begin
                    m_valid = 1'b1; m_tag = rv.addr[19:3]; m_data = rv.data;
                end
                if (rv.inval_cyc != 0) m_valid = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
